// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus multiplexer.
// Helpers work on a fixed 16-bit vector; callers cast to their channel count.
package bus_arb_pkg;

    localparam int MAX_CH = 16;
    localparam int IDX_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First set bit of req searching upward from ptr, wrapping at ch.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [IDX_W-1:0]  ptr,
        input logic [IDX_W:0]    ch
    );
        logic [MAX_CH-1:0] g;
        int                idx;
        g = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(ch)) idx = idx - int'(ch);
            if ((k < int'(ch)) && (g == '0) && req[idx[IDX_W-1:0]])
                g[idx[IDX_W-1:0]] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_mux_rr_arb_if.sv
// Channel-side and consumer-side signals of the round-robin bus multiplexer.
interface bus_mux_rr_arb_if #(
    parameter int N  = 16,
    parameter int CH = 4
);
    localparam int SW = $clog2(CH);

    logic [CH-1:0]   req_in;
    logic [CH*N-1:0] data_in;
    logic [CH-1:0]   last_in;
    logic            ready_in;
    logic [CH-1:0]   ack_out;
    logic [CH-1:0]   grant_out;
    logic [SW-1:0]   sel_out;
    logic            valid_out;
    logic [N-1:0]    data_out;

    modport master (
        output req_in, data_in, last_in, ready_in,
        input  ack_out, grant_out, sel_out, valid_out, data_out
    );

    modport slave (
        input  req_in, data_in, last_in, ready_in,
        output ack_out, grant_out, sel_out, valid_out, data_out
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester at or above ptr.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int CH = 4,
    localparam int SW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [CH-1:0] grant
);

    assign grant = CH'(rr_pick(MAX_CH'(req), IDX_W'(ptr), (IDX_W + 1)'(CH)));

endmodule

// File: rtl/bus_mux_rr_arb.sv
// CH-channel bus selector with round-robin arbitration, burst locking and a
// single registered valid/ready output stage.
module bus_mux_rr_arb
    import bus_arb_pkg::*;
#(
    parameter int N  = 16,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_mux_rr_arb_if.slave bus
);

    localparam int SW = $clog2(CH);

    arb_state_t    state;
    logic [SW-1:0] owner;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel_q;
    logic          valid_q;
    logic [N-1:0]  data_q;

    logic [CH-1:0] rr_grant;
    logic [CH-1:0] owner_mask;
    logic [CH-1:0] grant;
    logic          load;
    logic [SW-1:0] win_idx;
    logic [SW-1:0] next_ptr;
    logic [N-1:0]  win_data;
    logic          win_last;

    rr_arbiter #(.CH(CH)) u_rr_arbiter (
        .req   (bus.req_in),
        .ptr   (ptr),
        .grant (rr_grant)
    );

    assign owner_mask = CH'(1) << owner;

    // While locked only the burst owner may win; everything is masked during reset.
    always_comb begin
        grant = '0;
        if (rst_n) begin
            if (state == LOCKED) grant = owner_mask & bus.req_in;
            else                 grant = rr_grant;
        end
    end

    assign load     = (|grant) & (~valid_q | bus.ready_in);
    assign win_idx  = SW'(onehot_to_idx(MAX_CH'(grant)));
    assign win_data = bus.data_in[int'(win_idx)*N +: N];
    assign win_last = bus.last_in[win_idx];
    assign next_ptr = (win_idx == SW'(CH - 1)) ? '0 : win_idx + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            data_q  <= win_data;
            sel_q   <= win_idx;
            valid_q <= 1'b1;
            if (state == IDLE) begin
                if (win_last) begin
                    ptr <= next_ptr;
                end else begin
                    state <= LOCKED;
                    owner <= win_idx;
                end
            end else if (win_last) begin
                state <= IDLE;
                ptr   <= next_ptr;
            end
        end else if (bus.ready_in) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.grant_out = grant;
    assign bus.ack_out   = grant & {CH{load}};
    assign bus.sel_out   = sel_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;

endmodule

// File: tb/tb_bus_mux_rr_arb.sv
// Directed-vector bench for bus_mux_rr_arb: a CH=4 instance for the main
// behaviour and a CH=3 instance for non-power-of-two pointer wrap.
module tb_bus_mux_rr_arb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bus_mux_rr_arb_if #(.N(16), .CH(4)) bus_a ();
    bus_mux_rr_arb_if #(.N(16), .CH(3)) bus_b ();

    bus_mux_rr_arb #(.N(16), .CH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    bus_mux_rr_arb #(.N(16), .CH(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        ready;
        logic [63:0] din;
        logic [3:0]  ack;
        logic        valid;
        logic [1:0]  sel;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[23];

    localparam logic [63:0] DFLT = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] last,
                                input logic ready, input logic [63:0] din,
                                input logic [3:0] ack, input logic valid,
                                input logic [1:0] sel, input logic [15:0] data);
        vec_t v;
        v.req = req; v.last = last; v.ready = ready; v.din = din;
        v.ack = ack; v.valid = valid; v.sel = sel; v.data = data;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] last,
                                 input logic ready, input logic [63:0] din);
        bus_a.req_in   = req;
        bus_a.last_in  = last;
        bus_a.ready_in = ready;
        bus_a.data_in  = din;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b1, DFLT);
        bus_b.req_in   = '0;
        bus_b.last_in  = '0;
        bus_b.ready_in = 1'b1;
        bus_b.data_in  = {16'hD002, 16'hD001, 16'hD000};

        // Round robin, ch1 burst, idle drain, backpressure, owner drop, then a new lock.
        vecs[0]  = mk(4'b1111, 4'b1111, 1, DFLT, 4'b0001, 1, 2'd0, 16'hA000);
        vecs[1]  = mk(4'b1111, 4'b1111, 1, DFLT, 4'b0010, 1, 2'd1, 16'hA001);
        vecs[2]  = mk(4'b1111, 4'b1111, 1, DFLT, 4'b0100, 1, 2'd2, 16'hA002);
        vecs[3]  = mk(4'b1111, 4'b1111, 1, DFLT, 4'b1000, 1, 2'd3, 16'hA003);
        vecs[4]  = mk(4'b1111, 4'b1111, 1, DFLT, 4'b0001, 1, 2'd0, 16'hA000);
        vecs[5]  = mk(4'b0111, 4'b0101, 1, {16'hA003, 16'hA002, 16'hB101, 16'hA000}, 4'b0010, 1, 2'd1, 16'hB101);
        vecs[6]  = mk(4'b0111, 4'b0101, 1, {16'hA003, 16'hA002, 16'hB102, 16'hA000}, 4'b0010, 1, 2'd1, 16'hB102);
        vecs[7]  = mk(4'b0111, 4'b0111, 1, {16'hA003, 16'hA002, 16'hB103, 16'hA000}, 4'b0010, 1, 2'd1, 16'hB103);
        vecs[8]  = mk(4'b0101, 4'b0101, 1, DFLT, 4'b0100, 1, 2'd2, 16'hA002);
        vecs[9]  = mk(4'b0001, 4'b0001, 1, DFLT, 4'b0001, 1, 2'd0, 16'hA000);
        vecs[10] = mk(4'b0000, 4'b0000, 1, DFLT, 4'b0000, 0, 2'd0, 16'h0000);
        vecs[11] = mk(4'b0100, 4'b0100, 0, DFLT, 4'b0100, 1, 2'd2, 16'hA002);
        vecs[12] = mk(4'b1000, 4'b1000, 0, DFLT, 4'b0000, 1, 2'd2, 16'hA002);
        vecs[13] = mk(4'b1000, 4'b1000, 0, DFLT, 4'b0000, 1, 2'd2, 16'hA002);
        vecs[14] = mk(4'b1000, 4'b1000, 0, DFLT, 4'b0000, 1, 2'd2, 16'hA002);
        vecs[15] = mk(4'b1000, 4'b1000, 1, DFLT, 4'b1000, 1, 2'd3, 16'hA003);
        vecs[16] = mk(4'b1000, 4'b0000, 1, {16'hC301, 16'hA002, 16'hA001, 16'hA000}, 4'b1000, 1, 2'd3, 16'hC301);
        vecs[17] = mk(4'b0001, 4'b0001, 1, {16'hC302, 16'hA002, 16'hA001, 16'hA000}, 4'b0000, 0, 2'd0, 16'h0000);
        vecs[18] = mk(4'b0001, 4'b0001, 1, {16'hC302, 16'hA002, 16'hA001, 16'hA000}, 4'b0000, 0, 2'd0, 16'h0000);
        vecs[19] = mk(4'b1001, 4'b1001, 1, {16'hC302, 16'hA002, 16'hA001, 16'hA000}, 4'b1000, 1, 2'd3, 16'hC302);
        vecs[20] = mk(4'b0001, 4'b0001, 1, DFLT, 4'b0001, 1, 2'd0, 16'hA000);
        vecs[21] = mk(4'b0100, 4'b0100, 1, DFLT, 4'b0100, 1, 2'd2, 16'hA002);
        vecs[22] = mk(4'b1000, 4'b0000, 1, DFLT, 4'b1000, 1, 2'd3, 16'hA003);

        #3;
        checkOutput("reset_valid", 64'(bus_a.valid_out), 64'd0);
        checkOutput("reset_data",  64'(bus_a.data_out),  64'd0);
        checkOutput("reset_sel",   64'(bus_a.sel_out),   64'd0);
        checkOutput("reset_grant", 64'(bus_a.grant_out), 64'd0);
        checkOutput("reset_ack",   64'(bus_a.ack_out),   64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].req, vecs[i].last, vecs[i].ready, vecs[i].din);
            #1;
            checkOutput($sformatf("v%0d_ack", i), 64'(bus_a.ack_out), 64'(vecs[i].ack));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_valid", i), 64'(bus_a.valid_out), 64'(vecs[i].valid));
            if (vecs[i].valid) begin
                checkOutput($sformatf("v%0d_sel", i),  64'(bus_a.sel_out),  64'(vecs[i].sel));
                checkOutput($sformatf("v%0d_data", i), 64'(bus_a.data_out), 64'(vecs[i].data));
            end
            @(negedge clk);
        end

        // Locked on ch3 with a word in flight; asynchronous reset must clear it at once.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(bus_a.valid_out), 64'd0);
        checkOutput("midrst_data",  64'(bus_a.data_out),  64'd0);
        checkOutput("midrst_sel",   64'(bus_a.sel_out),   64'd0);
        checkOutput("midrst_grant", 64'(bus_a.grant_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 4'b1001, 1'b1, DFLT);
        #1;
        checkOutput("postrst_ack", 64'(bus_a.ack_out), 64'b0001);
        @(posedge clk);
        #1;
        checkOutput("postrst_valid", 64'(bus_a.valid_out), 64'd1);
        checkOutput("postrst_sel",   64'(bus_a.sel_out),   64'd0);
        checkOutput("postrst_data",  64'(bus_a.data_out),  64'hA000);
        @(negedge clk);
        applyStimulus(4'b0000, 4'b0000, 1'b1, DFLT);

        // Three-channel instance: pointer must wrap 2 -> 0 and never reach 3.
        bus_b.req_in  = 3'b111;
        bus_b.last_in = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput($sformatf("ch3_k%0d_ack", k), 64'(bus_b.ack_out), 64'(3'b001 << (k % 3)));
            @(posedge clk);
            #1;
            checkOutput($sformatf("ch3_k%0d_sel", k),  64'(bus_b.sel_out),  64'(k % 3));
            checkOutput($sformatf("ch3_k%0d_data", k), 64'(bus_b.data_out), 64'(16'hD000 + k % 3));
            checkOutput($sformatf("ch3_k%0d_range", k), 64'(bus_b.sel_out < 2'd3), 64'd1);
            @(negedge clk);
        end
        bus_b.req_in = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mux_rr_arb.md
Name: bus_mux_rr_arb

Overview:
- Parametrised successor to the datapath bus multiplexers: CH-channel, N-bit bus selector with round-robin arbitration, burst locking and one registered output stage with valid/ready handshake.
- Sits between multiple bus drivers (e.g. PC, MAR, MDR, ALU sources, or DMA/debug masters) and a single shared bus consumer.
- Replaces static select-driven muxing when sources contend.

Parameters:
- N, 16, data width per channel.
- CH, 4, number of channels (legal range 2..16).
- SW, $clog2(CH), width of the select index (derived; not overridable).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Req_In  input  CH  per-channel request; channel i presents a word when Req_In[i]=1.
- Data_In  input  CH*N  flattened channel data; channel i occupies bits [i*N +: N].
- Last_In  input  CH  per-channel end-of-burst flag, qualified by Req_In[i].
- Ready_In  input  1  downstream accepts Data_Out this cycle.
- Ack_Out  output  CH  one-hot pulse: channel's word was captured this cycle.
- Grant_Out  output  CH  one-hot current grant (combinational from state and Req_In); all-zero when there is no eligible request.
- Sel_Out  output  SW  index of the channel that sourced the current Data_Out word.
- Valid_Out  output  1  Data_Out holds a valid word.
- Data_Out  output  N  registered selected data.

Behaviour:
- Reset (async assert, sync release): Valid_Out=0, Data_Out=0, Sel_Out=0, rr pointer=0, state=IDLE. Ack_Out and Grant_Out evaluate to 0 while Reset_n=0.
- Load condition: load = (|Grant_Out) & (~Valid_Out | Ready_In).
  - On load, Data_Out <= winner's data, Sel_Out <= winner index, Valid_Out <= 1.
  - If Valid_Out & Ready_In & ~load, Valid_Out <= 0.
  - Full throughput: one word per cycle while Ready_In=1.
- Ack_Out = Grant_Out & {CH{load}}. A channel must hold Req/Data/Last stable until acked.
- Latency: word captured at edge k appears on Data_Out after edge k. Total latency is 1 cycle from request to Valid_Out when the output is empty.
- State machine:
  - IDLE: winner = first requesting channel searching upward from pointer, wrapping CH-1 -> 0.
    - Load with Last_In[w]=1: stay IDLE, pointer <= (w+1) mod CH.
    - Load with Last_In[w]=0: go to LOCKED, owner <= w.
  - LOCKED: Grant_Out = onehot(owner) & Req_In; all other requests are ignored.
    - Load with Last_In[owner]=1: go to IDLE, pointer <= (owner+1) mod CH.
    - Owner dropping Req mid-burst: no load, lock is held. No timeout.
- Backpressure: Valid_Out=1 & Ready_In=0 means no load. Data_Out and Sel_Out are held stable, no Ack, and state and pointer are unchanged.
- Simultaneous Ready_In and new load: the old word is consumed and the new word is loaded on the same edge.
- Pointer wrap: pointer is mod CH. For non-power-of-two CH, pointer never holds a value >= CH.
- Reset mid-burst: the lock is discarded and the in-flight output word is dropped.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}.
  - Function rr_pick(req, ptr) returning a one-hot vector.
  - Function onehot_to_idx.
- One sub-module: rr_arbiter (combinational priority rotate on Req_In/pointer, parametrised CH).
- The top holds the state, owner, pointer and output register.

Test Plan:
- Reset while Valid_Out=1 mid-burst -> Valid_Out=0, Data_Out=0, Sel_Out=0 immediately (async). After release, the first grant goes to the lowest requesting channel from pointer 0.
- CH=4, Req_In=4'b1111, Last_In=4'b1111, Ready_In=1, Data_In=ch i -> 16'hA000+i -> Data_Out sequence A000,A001,A002,A003,A000 on consecutive cycles, with Ack_Out rotating 0001,0010,0100,1000.
- Ch1 burst of 3 words (Last on 3rd) while ch0/ch2 request -> Data_Out shows three ch1 words contiguously, then ch2 (pointer=2), then ch0.
- Ready_In=0 for 3 cycles with Valid_Out=1 -> Data_Out/Sel_Out stable, Ack_Out=0. Ready_In=1 -> the next word loads on the same edge the held word is consumed.
- LOCKED on ch3, Req_In[3] drops for 2 cycles while ch0 requests -> no Ack to ch0 and Valid_Out falls after consumption. The burst resumes when Req_In[3] returns.
- CH=3 (non-power-of-two), all request with Last=1 -> Sel_Out cycles 0,1,2,0 and never reaches 3.
